// File: rtl/fetch_bundle_queue.sv
// rtl/fetch_bundle_queue.sv - fetch bundle queue between FetchStage1 and decode
// Circular buffer with registered head/tail/count and no fall-through.
module fetch_bundle_queue #(
  parameter int DEPTH    = 4,
  parameter int BUNDLE_W = 128,
  parameter int PC_W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       wrValid_i,
  input  logic [BUNDLE_W-1:0]        wrBundle_i,
  input  logic [PC_W-1:0]            wrPc_i,
  input  logic [3:0]                 wrBtbHit_i,
  input  logic [3:0]                 wrPred_i,
  output logic                       full_o,
  output logic                       almostFull_o,
  output logic                       rdValid_o,
  input  logic                       rdReady_i,
  output logic [BUNDLE_W-1:0]        rdBundle_o,
  output logic [PC_W-1:0]            rdPc_o,
  output logic [3:0]                 rdBtbHit_o,
  output logic [3:0]                 rdPred_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(DEPTH - 1);

  logic [BUNDLE_W-1:0] bundleMem [DEPTH];
  logic [PC_W-1:0]     pcMem     [DEPTH];
  logic [3:0]          btbHitMem [DEPTH];
  logic [3:0]          predMem   [DEPTH];

  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic [CNT_W-1:0] count;
  logic             doPush;
  logic             doPop;

  assign full_o       = (count == CNT_FULL);
  assign almostFull_o = (count >= CNT_AFULL);
  assign rdValid_o    = (count != '0);
  assign count_o      = count;

  // A full queue refuses the write even when a pop frees a slot this cycle.
  assign doPush = wrValid_i && !full_o && !flush_i;
  assign doPop  = rdValid_o && rdReady_i && !flush_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else if (flush_i) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (doPush) tailPtr <= tailPtr + PTR_ONE;
      if (doPop)  headPtr <= headPtr + PTR_ONE;
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is unreset; validity comes solely from count.
  always_ff @(posedge clk) begin
    if (doPush) begin
      bundleMem[tailPtr] <= wrBundle_i;
      pcMem[tailPtr]     <= wrPc_i;
      btbHitMem[tailPtr] <= wrBtbHit_i;
      predMem[tailPtr]   <= wrPred_i;
    end
  end

  always_comb begin
    rdBundle_o = '0;
    rdPc_o     = '0;
    rdBtbHit_o = '0;
    rdPred_o   = '0;
    if (rdValid_o) begin
      rdBundle_o = bundleMem[headPtr];
      rdPc_o     = pcMem[headPtr];
      rdBtbHit_o = btbHitMem[headPtr];
      rdPred_o   = predMem[headPtr];
    end
  end

endmodule

// File: tb/tb_fetch_bundle_queue.sv
// tb/tb_fetch_bundle_queue.sv - directed self-checking bench for fetch_bundle_queue
// Entry fields derive from the PC: bundle={4{pc}}, hit=pc[8:5], pred=pc[7:4].
module tb_fetch_bundle_queue;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush_i;
  logic         wrValid_i;
  logic [127:0] wrBundle_i;
  logic [31:0]  wrPc_i;
  logic [3:0]   wrBtbHit_i;
  logic [3:0]   wrPred_i;
  logic         full_o;
  logic         almostFull_o;
  logic         rdValid_o;
  logic         rdReady_i;
  logic [127:0] rdBundle_o;
  logic [31:0]  rdPc_o;
  logic [3:0]   rdBtbHit_o;
  logic [3:0]   rdPred_o;
  logic [2:0]   count_o;

  int nAsserts = 0;
  int nFails   = 0;
  logic [31:0] model [$];

  fetch_bundle_queue #(.DEPTH(4), .BUNDLE_W(128), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .wrValid_i(wrValid_i), .wrBundle_i(wrBundle_i), .wrPc_i(wrPc_i),
    .wrBtbHit_i(wrBtbHit_i), .wrPred_i(wrPred_i),
    .full_o(full_o), .almostFull_o(almostFull_o), .rdValid_o(rdValid_o),
    .rdReady_i(rdReady_i), .rdBundle_o(rdBundle_o), .rdPc_o(rdPc_o),
    .rdBtbHit_o(rdBtbHit_o), .rdPred_o(rdPred_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setWr(input logic v, input logic [31:0] pc);
    wrValid_i  = v;
    wrPc_i     = pc;
    wrBundle_i = {4{pc}};
    wrBtbHit_i = pc[8:5];
    wrPred_i   = pc[7:4];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkHead(input string tag, input logic [31:0] pc);
    chk({tag, "_pc"},     rdPc_o,     pc);
    chk({tag, "_bundle"}, rdBundle_o, {4{pc}});
    chk({tag, "_hit"},    rdBtbHit_o, pc[8:5]);
    chk({tag, "_pred"},   rdPred_o,   pc[7:4]);
  endtask

  task automatic chkEmpty(input string tag);
    chk({tag, "_count"},  count_o,   3'd0);
    chk({tag, "_valid"},  rdValid_o, 1'b0);
    chk({tag, "_full"},   full_o,    1'b0);
    chk({tag, "_afull"},  almostFull_o, 1'b0);
    chkHead(tag, 32'h0);
  endtask

  initial begin
    reset = 1'b1; flush_i = 1'b0; rdReady_i = 1'b0;
    setWr(1'b0, 32'h0);
    #12;
    chkEmpty("reset");
    @(negedge clk);
    reset = 1'b0;
    #6;  // now 1 time unit after a rising edge

    // first push right after reset, no fall-through before the edge
    setWr(1'b1, 32'h100);
    #1;
    chk("noFallThrough_valid", rdValid_o, 1'b0);
    tick();
    chk("push1_valid", rdValid_o, 1'b1);
    chk("push1_count", count_o, 3'd1);
    chkHead("push1", 32'h100);

    setWr(1'b1, 32'h120); tick();
    chk("c2_afull", almostFull_o, 1'b0);
    setWr(1'b1, 32'h140); tick();
    chk("c3_afull", almostFull_o, 1'b1);
    chk("c3_full",  full_o, 1'b0);
    setWr(1'b1, 32'h160); tick();
    chk("c4_full",  full_o, 1'b1);
    chk("c4_count", count_o, 3'd4);
    setWr(1'b1, 32'h180); tick();
    chk("push5_count", count_o, 3'd4);
    chkHead("push5_head", 32'h100);

    // drain in order
    setWr(1'b0, 32'h0);
    rdReady_i = 1'b1;
    chkHead("pop0", 32'h100); tick();
    chkHead("pop1", 32'h120); tick();
    chkHead("pop2", 32'h140); tick();
    chkHead("pop3", 32'h160); tick();
    chkEmpty("drained");
    tick();
    chk("popEmpty_count", count_o, 3'd0);
    rdReady_i = 1'b0;

    // full with simultaneous push and pop: only pop taken
    for (int i = 0; i < 4; i++) begin
      setWr(1'b1, 32'h200 + 32'(i) * 32'h20);
      tick();
    end
    chk("refill_full", full_o, 1'b1);
    setWr(1'b1, 32'h280);
    rdReady_i = 1'b1;
    tick();
    chk("fullPushPop_count", count_o, 3'd3);
    chk("fullPushPop_full",  full_o, 1'b0);
    chkHead("fullPushPop_head", 32'h220);
    setWr(1'b0, 32'h0);
    tick();
    chk("toTwo_count", count_o, 3'd2);
    chkHead("toTwo_head", 32'h240);

    // steady push+pop at count 2 across pointer wrap
    model.delete();
    model.push_back(32'h240);
    model.push_back(32'h260);
    for (int i = 0; i < 10; i++) begin
      logic [31:0] pc;
      pc = 32'h300 + 32'(i) * 32'h20;
      setWr(1'b1, pc);
      rdReady_i = 1'b1;
      chk("wrap_head", rdPc_o, model[0]);
      tick();
      void'(model.pop_front());
      model.push_back(pc);
      chk("wrap_count", count_o, 3'd2);
    end
    chkHead("wrapEnd_head", model[0]);
    rdReady_i = 1'b0;
    setWr(1'b1, 32'h500); tick();
    chk("pre_flush_count", count_o, 3'd3);

    // flush wins over a same-cycle push
    flush_i = 1'b1;
    setWr(1'b1, 32'h520);
    tick();
    flush_i = 1'b0;
    setWr(1'b0, 32'h0);
    chkEmpty("flush");
    tick();
    chk("postFlush_count", count_o, 3'd0);

    // asynchronous reset between edges
    setWr(1'b1, 32'h600); tick();
    setWr(1'b1, 32'h620); tick();
    setWr(1'b0, 32'h0);
    chk("preReset_count", count_o, 3'd2);
    #2;
    reset = 1'b1;
    #1;
    chkEmpty("asyncReset");
    #1;
    reset = 1'b0;
    setWr(1'b1, 32'h640);
    tick();
    chk("afterReset_count", count_o, 3'd1);
    chkHead("afterReset_head", 32'h640);
    setWr(1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/fetch_bundle_queue.md
FETCH_BUNDLE_QUEUE -- requirements
Module: fetch_bundle_queue

Interface
REQ-001 The block SHALL have one clock, clk, and one reset, reset, which is asynchronous and active-high.
REQ-002 Parameter DEPTH SHALL default to 4 and set the number of entries; it SHALL be a power of 2 and at least 2.
REQ-003 Parameter BUNDLE_W SHALL default to 128 and set the width of the 4-instruction fetch bundle.
REQ-004 Parameter PC_W SHALL default to 32 and set the width of the bundle PC.
REQ-005 The ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: clock, rising edge.
- reset, in, 1: async active-high reset.
- flush_i, in, 1: discard all entries (recovery or exception).
- wrValid_i, in, 1: FetchStage1 presents a valid bundle.
- wrBundle_i, in, BUNDLE_W: instruction bundle.
- wrPc_i, in, PC_W: PC of the bundle.
- wrBtbHit_i, in, 4: per-slot BTB hit.
- wrPred_i, in, 4: per-slot direction prediction.
- full_o, out, 1: no free entry; drives the upstream stall.
- almostFull_o, out, 1: count is DEPTH-1 or more.
- rdValid_o, out, 1: head entry is valid.
- rdReady_i, in, 1: downstream accepts the head entry.
- rdBundle_o, out, BUNDLE_W: head bundle.
- rdPc_o, out, PC_W: head PC.
- rdBtbHit_o, out, 4: head BTB hit bits.
- rdPred_o, out, 4: head prediction bits.
- count_o, out, clog2(DEPTH+1): occupancy.

Function
REQ-006 Push SHALL occur at a clk edge when wrValid_i=1, full_o=0 and flush_i=0; the entry is written at the tail, and the tail pointer advances by 1 modulo DEPTH.
REQ-007 Pop SHALL occur at a clk edge when rdValid_o=1, rdReady_i=1 and flush_i=0; the head pointer advances by 1 modulo DEPTH.
REQ-008 When push and pop occur in the same cycle, count SHALL stay unchanged and both pointers SHALL advance.
REQ-009 There SHALL be no fall-through: a bundle pushed at edge N SHALL be visible on rdValid_o/rd* no earlier than after edge N.
REQ-010 When full, wrValid_i SHALL be ignored even if a pop occurs in the same cycle; upstream holds the bundle and retries.
REQ-011 full_o SHALL equal (count==DEPTH), almostFull_o SHALL equal (count>=DEPTH-1), and rdValid_o SHALL equal (count!=0).
REQ-012 rd* data outputs SHALL be driven combinationally from the head entry when rdValid_o=1, and SHALL be forced to all-zero when rdValid_o=0.
REQ-013 flush_i SHALL have highest priority: at the edge, head, tail and count SHALL go to 0, and any same-cycle push or pop SHALL be discarded.
REQ-014 The count arithmetic SHALL never underflow below 0 or exceed DEPTH; pointers SHALL be clog2(DEPTH) bits and wrap naturally.
REQ-015 Entry storage SHALL not require reset; observable correctness SHALL depend only on the pointers and count.
REQ-016 Pop with rdValid_o=0 and push with wrValid_i=0 SHALL have no effect.
REQ-017 The bundle order SHALL be strictly FIFO, and the field association (bundle/PC/hit/pred) SHALL be preserved per entry.

Reset
REQ-018 Asserting reset SHALL immediately, without a clock, drive head=0, tail=0, count_o=0, full_o=0, almostFull_o=0, rdValid_o=0, and rd* outputs=0.
REQ-019 After reset deasserts, the first push SHALL be accepted at the first clk edge.
REQ-020 A reset asserted mid-operation SHALL discard all entries, identically to REQ-018.

Verification
REQ-021 The bench SHALL cover: push PC=0x100 at edge 1 with rdReady_i=0 -> after edge 1 rdValid_o=1, rdPc_o=0x100, count_o=1.
REQ-022 The bench SHALL cover: push 0x100, 0x120, 0x140, 0x160 with no pops (DEPTH=4) -> full_o=1, almostFull_o=1 from count 3; a fifth push of 0x180 is ignored; pops then return 0x100, 0x120, 0x140, 0x160 in order.
REQ-023 The bench SHALL cover: full queue, simultaneous wrValid_i=1 and rdReady_i=1 -> the pop is taken, the push is ignored, count_o=3.
REQ-024 The bench SHALL cover: count=2, simultaneous push and pop -> count stays 2 and the head advances; run 10 cycles to exercise pointer wrap, with FIFO order intact.
REQ-025 The bench SHALL cover: count=3, flush_i=1 together with wrValid_i=1 -> after the edge count_o=0, rdValid_o=0, rd* outputs=0.
REQ-026 The bench SHALL cover: reset asserted between clock edges with count=2 -> rdValid_o=0 and count_o=0 before the next edge.
